// File: rtl/lzc_norm_pipe.sv
// Pipelined leading-zero count and normalise: log barrel shifter split into STAGES register groups with valid/ready flow.
// Optional exponent adjustment (exp_in - distance, underflow flag) is enabled by defining LZC_NORM_EXP_ADJUST_EN.
module lzc_norm_pipe #(
  parameter int WIDTH  = 24,
  parameter int WIDTHR = 5,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
`ifdef LZC_NORM_EXP_ADJUST_EN
  ,
  parameter int EXP_W  = 8
`endif
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTHR-1:0]  distance,
  output logic               zero,
  output logic [TAG_W-1:0]   out_tag
`ifdef LZC_NORM_EXP_ADJUST_EN
  ,
  input  logic [EXP_W-1:0]   exp_in,
  output logic [EXP_W-1:0]   exp_out,
  output logic               underflow
`endif
);

  generate
    if (2 ** WIDTHR <= WIDTH) begin : gBadWidthr
      $error("lzc_norm_pipe: 2**WIDTHR must exceed WIDTH");
    end
    if (STAGES < 1 || STAGES > WIDTHR) begin : gBadStages
      $error("lzc_norm_pipe: STAGES must lie in 1..WIDTHR");
    end
  endgenerate

  // First shifter level of group g; earlier groups absorb any remainder.
  function automatic int groupStart(input int g);
    int s;
    s = 0;
    for (int i = 0; i < g; i++) s += (WIDTHR - s + STAGES - i - 1) / (STAGES - i);
    return s;
  endfunction

  logic [STAGES-1:0] stageValid;
  logic [STAGES-1:0] stageZero;
  logic [WIDTH-1:0]  stageVal  [STAGES];
  logic [WIDTHR-1:0] stageDist [STAGES];
  logic [TAG_W-1:0]  stageTag  [STAGES];

  logic [STAGES-1:0] en;
  logic [STAGES-1:0] upValid;
  logic [STAGES-1:0] upZero;
  logic [TAG_W-1:0]  upTag    [STAGES];
  logic [WIDTH-1:0]  nextVal  [STAGES];
  logic [WIDTHR-1:0] nextDist [STAGES];
  logic [WIDTHR-1:0] finalDist;

  always_comb begin
    en = '0;
    en[STAGES-1] = ~stageValid[STAGES-1] | out_ready;
    for (int g = STAGES - 2; g >= 0; g--) en[g] = ~stageValid[g] | en[g+1];
  end

  assign in_ready = en[0];

  always_comb begin
    upValid  = '0;
    upZero   = '0;
    upValid[0] = in_valid;
    upZero[0]  = (data == '0);
    upTag[0]   = in_tag;
    for (int g = 1; g < STAGES; g++) begin
      upValid[g] = stageValid[g-1];
      upZero[g]  = stageZero[g-1];
      upTag[g]   = stageTag[g-1];
    end
  end

  // Each group continues from the previous group's register.
  always_comb begin : datapath
    logic [WIDTH-1:0]  cur;
    logic [WIDTHR-1:0] curDist;
    int amt;
    cur = data;
    curDist = '0;
    amt = 0;
    for (int g = 0; g < STAGES; g++) begin
      for (int k = groupStart(g); k < groupStart(g + 1); k++) begin
        amt = 1 << (WIDTHR - 1 - k);
        if ((amt >= WIDTH) ? (cur == '0) : ((cur >> (WIDTH - amt)) == '0)) begin
          cur = cur << amt;
          curDist = curDist | WIDTHR'(amt);
        end
      end
      nextVal[g]  = cur;
      nextDist[g] = curDist;
      cur = stageVal[g];
      curDist = stageDist[g];
    end
  end

  // An all-zero word would otherwise report the saturated barrel count.
  assign finalDist = upZero[STAGES-1] ? WIDTHR'(WIDTH) : nextDist[STAGES-1];

`ifdef LZC_NORM_EXP_ADJUST_EN
  logic [EXP_W-1:0] stageExp [STAGES];
  logic [EXP_W-1:0] upExp    [STAGES];
  logic [EXP_W-1:0] adjExp;
  logic             adjUnder;
  logic             underflowReg;

  always_comb begin
    upExp[0] = exp_in;
    for (int g = 1; g < STAGES; g++) upExp[g] = stageExp[g-1];
  end

  assign adjUnder = upZero[STAGES-1] | (int'(finalDist) > int'(upExp[STAGES-1]));
  assign adjExp   = adjUnder ? '0 : upExp[STAGES-1] - EXP_W'(finalDist);
  assign exp_out   = stageExp[STAGES-1];
  assign underflow = underflowReg;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stageValid <= '0;
      stageZero  <= '0;
      for (int g = 0; g < STAGES; g++) begin
        stageVal[g]  <= '0;
        stageDist[g] <= '0;
        stageTag[g]  <= '0;
`ifdef LZC_NORM_EXP_ADJUST_EN
        stageExp[g]  <= '0;
`endif
      end
`ifdef LZC_NORM_EXP_ADJUST_EN
      underflowReg <= 1'b0;
`endif
    end else begin
      for (int g = 0; g < STAGES; g++) begin
        if (en[g]) begin
          stageValid[g] <= upValid[g];
          stageZero[g]  <= upZero[g];
          stageVal[g]   <= nextVal[g];
          stageTag[g]   <= upTag[g];
          stageDist[g]  <= (g == STAGES - 1) ? finalDist : nextDist[g];
`ifdef LZC_NORM_EXP_ADJUST_EN
          stageExp[g]   <= (g == STAGES - 1) ? adjExp : upExp[g];
`endif
        end
      end
`ifdef LZC_NORM_EXP_ADJUST_EN
      if (en[STAGES-1]) underflowReg <= adjUnder;
`endif
    end
  end

  assign out_valid = stageValid[STAGES-1];
  assign result    = stageVal[STAGES-1];
  assign distance  = stageDist[STAGES-1];
  assign zero      = stageZero[STAGES-1];
  assign out_tag   = stageTag[STAGES-1];

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Scoreboard bench for lzc_norm_pipe (WIDTH=24, STAGES=2); exercises exp adjustment when LZC_NORM_EXP_ADJUST_EN is defined.
module tb_lzc_norm_pipe;
  localparam int WIDTH = 24, WIDTHR = 5, STAGES = 2, TAG_W = 4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b1;
  logic [WIDTH-1:0]  data = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              in_ready, out_valid, zero;
  logic [WIDTH-1:0]  result;
  logic [WIDTHR-1:0] distance;
  logic [TAG_W-1:0]  out_tag;
`ifdef LZC_NORM_EXP_ADJUST_EN
  logic [7:0]        exp_in = '0;
  logic [7:0]        exp_out;
  logic              underflow;
`endif

  always #5 clock = ~clock;

  lzc_norm_pipe #(.WIDTH(WIDTH), .WIDTHR(WIDTHR), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .distance(distance), .zero(zero), .out_tag(out_tag)
`ifdef LZC_NORM_EXP_ADJUST_EN
    , .exp_in(exp_in), .exp_out(exp_out), .underflow(underflow)
`endif
  );

  int compared = 0;
  int mismatched = 0;
  int received = 0;
  int stallTotal = 0;
  logic [63:0] scoreQ[$];

  function automatic logic [63:0] model(input logic [23:0] d, input logic [3:0] t, input logic [7:0] e);
    int n;
    logic [23:0] r;
    logic z;
    n = 0;
    while (n < 24 && d[23-n] == 1'b0) n++;
    z = (d == 24'h0);
    r = z ? 24'h0 : d << n;
`ifdef LZC_NORM_EXP_ADJUST_EN
    begin
      logic uf;
      logic [7:0] eo;
      uf = z || (n > int'(e));
      eo = uf ? 8'h0 : e - 8'(n);
      return {21'b0, uf, eo, r, 5'(n), z, t};
    end
`else
    return {30'b0, r, 5'(n), z, t} | (64'(e) & 64'h0);
`endif
  endfunction

  function automatic logic [63:0] packObs();
`ifdef LZC_NORM_EXP_ADJUST_EN
    return {21'b0, underflow, exp_out, result, distance, zero, out_tag};
`else
    return {30'b0, result, distance, zero, out_tag};
`endif
  endfunction

  task automatic checkOutput(input string tagName, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tagName, obs, expv);
    end
  endtask

  // Pops one expected word per output handshake.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (scoreQ.size() == 0) begin
        compared++;
        mismatched++;
        $error("[TB] FAIL unexpected_output observed=%h expected=none", packObs());
      end else begin
        checkOutput("scoreboard", packObs(), scoreQ.pop_front());
      end
      received++;
    end
  end

  task automatic applyStimulus(input logic [23:0] d, input logic [3:0] t, input logic [7:0] e);
    int waits;
    bit done;
    waits = 0;
    done = 1'b0;
    in_valid = 1'b1;
    data = d;
    in_tag = t;
`ifdef LZC_NORM_EXP_ADJUST_EN
    exp_in = e;
`endif
    while (!done && waits < 200) begin
      @(negedge clock);
      if (in_ready) begin
        scoreQ.push_back(model(d, t, e));
        done = 1'b1;
      end else begin
        waits++;
      end
    end
    stallTotal += waits;
    checkOutput("accept", 64'(done), 64'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int c;
    c = 0;
    while (scoreQ.size() != 0 && c < 100) begin
      @(posedge clock);
      #1;
      c++;
    end
    checkOutput("drain", 64'(scoreQ.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int base;
    logic [63:0] heldExp;

    #2 reset_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_result", 64'(result), 64'd0);
    checkOutput("reset_distance", 64'(distance), 64'd0);
    checkOutput("reset_zero", 64'(zero), 64'd0);
    checkOutput("reset_out_tag", 64'(out_tag), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Single word latency and value
    out_ready = 1'b1;
    applyStimulus(24'h000001, 4'h3, 8'd0);
    checkOutput("latency_early", 64'(out_valid), 64'd0);
    @(posedge clock);
    #1;
    checkOutput("latency_valid", 64'(out_valid), 64'd1);
    checkOutput("one_distance", 64'(distance), 64'd23);
    checkOutput("one_result", 64'(result), 64'h800000);
    checkOutput("one_zero", 64'(zero), 64'd0);

    // All-zero word
    applyStimulus(24'h000000, 4'hA, 8'd3);
    @(posedge clock);
    #1;
    checkOutput("zero_distance", 64'(distance), 64'd24);
    checkOutput("zero_result", 64'(result), 64'd0);
    checkOutput("zero_flag", 64'(zero), 64'd1);
    checkOutput("zero_tag", 64'(out_tag), 64'hA);
    waitDrain();

    // Back-to-back stream
    base = received;
    stallTotal = 0;
    for (int i = 0; i < 2048; i++)
      applyStimulus(24'(i) << (i % 13), 4'(i), 8'(i));
    checkOutput("stream_stalls", 64'(stallTotal), 64'd0);
    waitDrain();
    checkOutput("stream_count", 64'(received - base), 64'd2048);

    // Stall with full pipe
    out_ready = 1'b0;
    applyStimulus(24'h0000F0, 4'h1, 8'd30);
    applyStimulus(24'h123456, 4'h2, 8'd40);
    heldExp = model(24'h0000F0, 4'h1, 8'd30);
    in_valid = 1'b1;
    data = 24'h000ABC;
    in_tag = 4'h3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_hold", packObs(), heldExp);
    end
    @(posedge clock);
    #1 out_ready = 1'b1;
    applyStimulus(24'h000ABC, 4'h3, 8'd50);
    waitDrain();

    // Reset with two words in flight
    out_ready = 1'b0;
    applyStimulus(24'h00ABCD, 4'h4, 8'd9);
    applyStimulus(24'h000777, 4'h5, 8'd9);
    reset_n = 1'b0;
    #1;
    checkOutput("reset_flush_valid", 64'(out_valid), 64'd0);
    scoreQ.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("post_reset_valid", 64'(out_valid), 64'd0);
    applyStimulus(24'h00F000, 4'h6, 8'd9);
    @(posedge clock);
    #1;
    checkOutput("post_reset_out_valid", 64'(out_valid), 64'd1);
    checkOutput("post_reset_distance", 64'(distance), 64'd8);
    checkOutput("post_reset_result", 64'(result), 64'hF00000);
    waitDrain();

`ifdef LZC_NORM_EXP_ADJUST_EN
    applyStimulus(24'h000400, 4'h7, 8'd5);
    @(posedge clock);
    #1;
    checkOutput("exp_underflow", 64'(underflow), 64'd1);
    checkOutput("exp_out_zero", 64'(exp_out), 64'd0);
    applyStimulus(24'h000400, 4'h8, 8'd20);
    @(posedge clock);
    #1;
    checkOutput("exp_no_underflow", 64'(underflow), 64'd0);
    checkOutput("exp_out_seven", 64'(exp_out), 64'd7);
    waitDrain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
